// File: rtl/alu32_pkg.sv
// Shared types and constants for the adder flag stage: default widths, NZCV bit
// positions and the buffered entry layout {result, nzcv, tag}.
package alu32_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int TAG_W_DEF = 4;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic [WIDTH_DEF-1:0] result;
      logic [3:0]           nzcv;
      logic [TAG_W_DEF-1:0] tag;
   } alu_entry_t;

   function automatic logic [3:0] nzcv_pack(input logic n, input logic z,
                                            input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu32_skid2.sv
// Generic 2-entry valid/ready buffer; in_ready depends only on the registered
// occupancy so it never combinationally follows out_ready.
module alu32_skid2 #(
   parameter int ENTRY_W = 40
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ENTRY_W-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ENTRY_W-1:0] out_data
);

   logic [1:0]         count_q, count_d;
   logic [ENTRY_W-1:0] e0_q, e0_d, e1_q, e1_d;
   logic               push, pop;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = e0_q;

   always_comb begin
      count_d = count_q;
      e0_d    = e0_q;
      e1_d    = e1_q;
      case ({push, pop})
         2'b10: begin
            count_d = count_q + 2'd1;
            if (count_q == 2'd0) e0_d = in_data;
            else                 e1_d = in_data;
         end
         2'b01: begin
            count_d = count_q - 2'd1;
            // Head keeps its last value when draining to empty.
            if (count_q == 2'd2) e0_d = e1_q;
         end
         2'b11: begin
            // Only reachable at count 1: the new entry replaces the head.
            e0_d = in_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= 2'd0;
         e0_q    <= '0;
         e1_q    <= '0;
      end else begin
         count_q <= count_d;
         e0_q    <= e0_d;
         e1_q    <= e1_d;
      end
   end

endmodule

// File: rtl/alu32_flag_stage.sv
// Registered NZCV flag stage behind the 32-bit CLA adder, buffered by a 2-entry skid.
// Optional sticky overflow register enabled by defining ALU32_FLAG_STICKY_EN.
module alu32_flag_stage
   import alu32_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_s,
   input  logic             in_co,
   input  logic             in_co_prev,
   input  logic             in_sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_n,
   output logic             out_z,
   output logic             out_c,
   output logic             out_v,
   output logic [TAG_W-1:0] out_tag
`ifdef ALU32_FLAG_STICKY_EN
   ,
   output logic             ovf_sticky,
   input  logic             ovf_clr
`endif
);

   localparam int ENTRY_W = WIDTH + 4 + TAG_W;

   logic               carry_in;
   logic [3:0]         nzcv_in, nzcv_out;
   logic [ENTRY_W-1:0] ent_in, ent_out;

   // For subtraction the adder's carry-out is an inverted borrow.
   assign carry_in = in_sub ? ~in_co : in_co;
   assign nzcv_in  = nzcv_pack(in_s[WIDTH-1], (in_s == '0), carry_in, in_co ^ in_co_prev);
   assign ent_in   = {in_s, nzcv_in, in_tag};

   alu32_skid2 #(
      .ENTRY_W(ENTRY_W)
   ) u_skid (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (ent_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (ent_out)
   );

   assign out_result = ent_out[ENTRY_W-1 -: WIDTH];
   assign nzcv_out   = ent_out[TAG_W +: 4];
   assign out_tag    = ent_out[TAG_W-1:0];
   assign out_n      = nzcv_out[FLAG_N];
   assign out_z      = nzcv_out[FLAG_Z];
   assign out_c      = nzcv_out[FLAG_C];
   assign out_v      = nzcv_out[FLAG_V];

`ifdef ALU32_FLAG_STICKY_EN
   logic ovf_sticky_q, ovf_sticky_d;
   logic push;

   assign push = in_valid & in_ready;

   // Set has priority over clear so no overflow event is lost.
   always_comb begin
      ovf_sticky_d = ovf_sticky_q;
      if (ovf_clr)                ovf_sticky_d = 1'b0;
      if (push & nzcv_in[FLAG_V]) ovf_sticky_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ovf_sticky_q <= 1'b0;
      else          ovf_sticky_q <= ovf_sticky_d;
   end

   assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_alu32_flag_stage.sv
// Directed self-checking bench for alu32_flag_stage (sticky checks when
// ALU32_FLAG_STICKY_EN is defined).
module tb_alu32_flag_stage;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_s;
   logic        in_co;
   logic        in_co_prev;
   logic        in_sub;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_n, out_z, out_c, out_v;
   logic [3:0]  out_tag;
`ifdef ALU32_FLAG_STICKY_EN
   logic        ovf_sticky;
   logic        ovf_clr;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   alu32_flag_stage #(.WIDTH(32), .TAG_W(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_s      (in_s),
      .in_co     (in_co),
      .in_co_prev(in_co_prev),
      .in_sub    (in_sub),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_result(out_result),
      .out_n     (out_n),
      .out_z     (out_z),
      .out_c     (out_c),
      .out_v     (out_v),
      .out_tag   (out_tag)
`ifdef ALU32_FLAG_STICKY_EN
      ,
      .ovf_sticky(ovf_sticky),
      .ovf_clr   (ovf_clr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] s, input logic co, input logic cop,
                        input logic sub, input logic [3:0] tag);
      in_valid   = 1'b1;
      in_s       = s;
      in_co      = co;
      in_co_prev = cop;
      in_sub     = sub;
      in_tag     = tag;
   endtask

   function automatic logic [31:0] flags();
      return {28'd0, out_n, out_z, out_c, out_v};
   endfunction

   initial begin
      int recv;
      logic [31:0] s;
      logic [3:0]  exp_f;

      reset_n    = 1'b0;
      in_valid   = 1'b0;
      in_s       = '0;
      in_co      = 1'b0;
      in_co_prev = 1'b0;
      in_sub     = 1'b0;
      in_tag     = '0;
      out_ready  = 1'b0;
`ifdef ALU32_FLAG_STICKY_EN
      ovf_clr    = 1'b0;
`endif
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", out_result, 32'd0);
      check("rst_flags", flags(), 32'd0);
      check("rst_tag", {28'd0, out_tag}, 32'd0);
      step();
      step();
      reset_n = 1'b1;
      step();
      check("rel_in_ready", {31'd0, in_ready}, 32'd1);

      // Flag vectors, streamed back-to-back
      out_ready = 1'b1;
      drive(32'h8000_0000, 1'b0, 1'b1, 1'b0, 4'd1);
      step();
      check("add_valid", {31'd0, out_valid}, 32'd1);
      check("add_result", out_result, 32'h8000_0000);
      check("add_nzcv", flags(), 32'b1001);
      check("add_tag", {28'd0, out_tag}, 32'd1);
      drive(32'h0000_0000, 1'b1, 1'b1, 1'b1, 4'd2);
      step();
      check("sub55_result", out_result, 32'd0);
      check("sub55_nzcv", flags(), 32'b0100);
      check("sub55_tag", {28'd0, out_tag}, 32'd2);
      drive(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 4'd3);
      step();
      check("sub35_result", out_result, 32'hFFFF_FFFE);
      check("sub35_nzcv", flags(), 32'b1010);
      in_valid = 1'b0;
      step();
      check("drain_empty", {31'd0, out_valid}, 32'd0);

      // Backpressure
      out_ready = 1'b0;
      drive(32'h11, 1'b0, 1'b0, 1'b0, 4'd1);
      step();
      check("bp_ready_after1", {31'd0, in_ready}, 32'd1);
      drive(32'h22, 1'b0, 1'b0, 1'b0, 4'd2);
      step();
      check("bp_ready_full", {31'd0, in_ready}, 32'd0);
      drive(32'h33, 1'b0, 1'b0, 1'b0, 4'd3);
      step();
      check("bp_ready_held", {31'd0, in_ready}, 32'd0);
      check("bp_head_tag", {28'd0, out_tag}, 32'd1);
      step();
      check("bp_head_stable", out_result, 32'h11);
      out_ready = 1'b1;
      step();
      check("bp_out2_tag", {28'd0, out_tag}, 32'd2);
      check("bp_out2_ready", {31'd0, in_ready}, 32'd1);
      step();
      check("bp_out3_tag", {28'd0, out_tag}, 32'd3);
      check("bp_out3_result", out_result, 32'h33);
      in_valid = 1'b0;
      step();
      check("bp_drained", {31'd0, out_valid}, 32'd0);

      // Streaming, one per cycle
      recv = 0;
      for (int i = 0; i < 16; i++) begin
         s = i * 32'h1111_1111;
         drive(s, i[0], i[1], i[2], i[3:0]);
         step();
         if (out_valid) recv++;
         exp_f = {s[31], (s == 32'd0), (i[2] ? ~i[0] : i[0]), i[0] ^ i[1]};
         check("stream_result", out_result, s);
         check("stream_nzcv", flags(), {28'd0, exp_f});
         check("stream_ready", {31'd0, in_ready}, 32'd1);
      end
      in_valid = 1'b0;
      step();
      check("stream_count", recv, 32'd16);
      check("stream_empty", {31'd0, out_valid}, 32'd0);

      // Reset while full
      out_ready = 1'b0;
      drive(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 4'hA);
      step();
      drive(32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 4'hB);
      step();
      check("mid_full", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_result", out_result, 32'd0);
      check("mid_rst_flags", flags(), 32'd0);
      check("mid_rst_tag", {28'd0, out_tag}, 32'd0);
      step();
      reset_n = 1'b1;
      out_ready = 1'b1;
      step();
      check("post_rst_ready", {31'd0, in_ready}, 32'd1);
      check("post_rst_empty", {31'd0, out_valid}, 32'd0);
      step();
      check("post_rst_no_old", {31'd0, out_valid}, 32'd0);
      drive(32'h55, 1'b0, 1'b0, 1'b0, 4'd5);
      step();
      check("post_rst_new_tag", {28'd0, out_tag}, 32'd5);
      check("post_rst_new_res", out_result, 32'h55);

`ifdef ALU32_FLAG_STICKY_EN
      check("sticky_clear0", {31'd0, ovf_sticky}, 32'd0);
      drive(32'h1, 1'b1, 1'b0, 1'b0, 4'd6);
      step();
      check("sticky_set", {31'd0, ovf_sticky}, 32'd1);
      drive(32'h2, 1'b0, 1'b0, 1'b0, 4'd7);
      step();
      check("sticky_hold", {31'd0, ovf_sticky}, 32'd1);
      drive(32'h3, 1'b0, 1'b1, 1'b0, 4'd8);
      ovf_clr = 1'b1;
      step();
      check("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);
      in_valid = 1'b0;
      step();
      check("sticky_cleared", {31'd0, ovf_sticky}, 32'd0);
      ovf_clr = 1'b0;
`endif
      in_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
